rowwise_sequencer: RTL and testbench
====================================

Name: rowwise_sequencer

Overview:
- Initiator and memory-side responder for the rowwise functional unit.
- Buffers rowwise commands (op, src1, src2, dst) from the controller and hands them to the FU with a one-shot in_valid/in_ready handshake.
- Owns the vector storage: serves the FU's two read operands at the FU-driven element address and captures the FU's write-back into the destination vector.
- Host port loads and unloads vectors while idle.

Parameters:
- NUM_VECTORS, 8, number of D-element vectors held; VID_W = $clog2(NUM_VECTORS).
- CMD_DEPTH, 4, command FIFO depth; power of two, at least 2.
- D (config_pkg), elements per vector; element type fixed_point_t, element index type DI_t.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  FIFO not full
- cmd_op_i  in  operation_t  operation
- cmd_src1_i, cmd_src2_i, cmd_dst_i  in  VID_W each  vector IDs
- fu_in_ready_i  in  1  FU idle
- fu_in_valid_o  out  1  issue strobe to FU
- fu_operation_o  out  operation_t  held operation for the active command
- fu_addr_i  in  DI_t  FU element address
- fu_w_en_i  in  1  FU write enable
- fu_w_data_i  in  fixed_point_t  FU result
- fu_vector1_r_data_o, fu_vector2_r_data_o  out  fixed_point_t  operands
- done_o  out  1  one-cycle completion pulse
- done_dst_o  out  VID_W  destination vector ID of the completed command
- busy_o  out  1  FIFO non-empty, or state not IDLE
- host_en_i, host_we_i  in  1 each  host access and host write
- host_vec_i  in  VID_W  host vector ID
- host_addr_i  in  DI_t  host element index
- host_wdata_i  in  fixed_point_t  host write data
- host_ready_o  out  1  host access accepted
- host_rdata_o  out  fixed_point_t  registered host read data

Behaviour:
- Reset, asynchronous: state = IDLE; FIFO empty; cmd_ready_o = 1; fu_in_valid_o = 0; done_o = 0; done_dst_o = 0; host_rdata_o = 0; active registers = 0. Storage contents are not reset.
- Reset mid-operation abandons the active and queued commands with no done_o. The FU shares rst_ni.
- Command FIFO:
  - Push on cmd_valid_i && cmd_ready_o.
  - cmd_ready_o = !full.
  - Push when full is ignored.
  - Pointers wrap modulo CMD_DEPTH.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
- State IDLE:
  - FIFO non-empty and no host access this cycle: latch head op/src1/src2/dst into active registers, pop, go to ISSUE.
- State ISSUE:
  - fu_in_valid_o = 1.
  - fu_in_valid_o && fu_in_ready_i: go to BUSY.
  - Otherwise hold with valid high.
- State BUSY:
  - fu_in_valid_o = 0.
  - Reads are combinational: fu_vector1_r_data_o = mem[src1][fu_addr_i]; fu_vector2_r_data_o = mem[src2][fu_addr_i].
  - fu_w_en_i: mem[dst][fu_addr_i] <= fu_w_data_i at the clock edge.
  - fu_w_en_i && fu_addr_i == D-1: go to IDLE; done_o = 1 and done_dst_o = dst on the next cycle, for exactly one cycle.
- fu_operation_o = active op in ISSUE and BUSY; it is held stable for the whole operation. In IDLE it is 0.
- Operand reads are combinational and writes are registered, so src == dst (in-place) and src1 == src2 both give correct element-wise results.
- Latency:
  - Command to fu_in_valid_o: 2 cycles (push edge, latch edge) when the FU is ready.
  - Issue to done_o: D+2 cycles.
- Host port:
  - host_ready_o = (state == IDLE) && FIFO empty.
  - host_en_i && host_ready_o && host_we_i: writes mem[vec][addr].
  - host_en_i && host_ready_o && !host_we_i: host_rdata_o <= mem[vec][addr], 1-cycle latency.
  - Host access while not ready is dropped; host_rdata_o holds.
- A host access in IDLE in the same cycle as a command push: the host access completes. The command issues on the following cycle.
- fu_w_en_i outside BUSY is ignored; storage is unchanged.

Optional Feature:
- ROWWISE_SEQ_PERF_EN.
- Defined:
  - Adds out ports perf_cmds_o [31:0] (completed commands) and perf_busy_cycles_o [31:0] (cycles in ISSUE or BUSY).
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Host load v0[i] = i, v1[i] = 2. Command ADD src1=0, src2=1, dst=2. -> One fu_in_valid_o pulse; done_o one cycle with done_dst_o = 2; host reads v2[i] = i+2 for all i.
- In-place SUB src1=2, src2=1, dst=2 after test 1 -> v2[i] = i; done_o after D+2 cycles from issue.
- Push 5 commands back-to-back with CMD_DEPTH=4 and the FU held not-ready. -> cmd_ready_o = 0 after the 4th FIFO entry; all accepted commands complete in order; done_dst_o sequence matches.
- fu_in_ready_i held low for 10 cycles in ISSUE -> fu_in_valid_o stays high and fu_operation_o is stable; BUSY is entered on the first ready cycle.
- Assert rst_ni low at element D/2 of a MUL -> outputs at reset values immediately; no done_o; FIFO empty; host_ready_o = 1 after release.
- Host write while BUSY -> host_ready_o = 0 and the storage is unchanged. Under ROWWISE_SEQ_PERF_EN, perf_cmds_o = 2 after tests 1 and 2.

Source files
------------

// File: rtl/rowwise_sequencer.sv
// rowwise_sequencer -- command initiator and vector-storage responder for the
// rowwise functional unit.
//
// Commands (op, src1, src2, dst) are queued in a small FIFO, issued to the FU
// with a one-shot fu_in_valid_o/fu_in_ready_i handshake, and then the FU walks
// the element addresses itself: this block serves both operand reads
// combinationally at fu_addr_i and captures the FU write-back into the
// destination vector. A write of the last element completes the command and
// produces a one-cycle done_o pulse tagged with the destination vector ID.
// The host port loads/unloads vectors, but only while idle with an empty queue.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cmd_*                    command offer (valid/ready) and fields
//   fu_in_ready_i/valid_o    issue handshake with the FU
//   fu_operation_o           operation of the active command (0 when idle)
//   fu_addr_i, fu_w_en_i,
//   fu_w_data_i              FU element address and write-back
//   fu_vector{1,2}_r_data_o  operand read data at fu_addr_i
//   done_o, done_dst_o       completion pulse and destination vector ID
//   busy_o                   queue non-empty or a command in flight
//   host_*                   host vector load/unload port
//
// Optional build macro ROWWISE_SEQ_PERF_EN adds perf_cmds_o (completed
// commands) and perf_busy_cycles_o (cycles spent in ISSUE or BUSY).

package config_pkg;
    localparam int unsigned D    = 8;
    localparam int unsigned DI_W = $clog2(D);

    typedef logic signed [15:0] fixed_point_t;
    typedef logic [DI_W-1:0]    DI_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_MAX = 2'd3
    } operation_t;
endpackage

module rowwise_sequencer
    import config_pkg::*;
#(
    parameter  int unsigned NUM_VECTORS = 8,
    parameter  int unsigned CMD_DEPTH   = 4,
    localparam int unsigned VID_W       = $clog2(NUM_VECTORS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,

    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  operation_t         cmd_op_i,
    input  logic [VID_W-1:0]   cmd_src1_i,
    input  logic [VID_W-1:0]   cmd_src2_i,
    input  logic [VID_W-1:0]   cmd_dst_i,

    input  logic               fu_in_ready_i,
    output logic               fu_in_valid_o,
    output operation_t         fu_operation_o,
    input  DI_t                fu_addr_i,
    input  logic               fu_w_en_i,
    input  fixed_point_t       fu_w_data_i,
    output fixed_point_t       fu_vector1_r_data_o,
    output fixed_point_t       fu_vector2_r_data_o,

    output logic               done_o,
    output logic [VID_W-1:0]   done_dst_o,
    output logic               busy_o,

    input  logic               host_en_i,
    input  logic               host_we_i,
    input  logic [VID_W-1:0]   host_vec_i,
    input  DI_t                host_addr_i,
    input  fixed_point_t       host_wdata_i,
    output logic               host_ready_o,
    output fixed_point_t       host_rdata_o
`ifdef ROWWISE_SEQ_PERF_EN
    ,
    output logic [31:0]        perf_cmds_o,
    output logic [31:0]        perf_busy_cycles_o
`endif
);

    localparam int unsigned PTR_W = $clog2(CMD_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    typedef struct packed {
        operation_t       op;
        logic [VID_W-1:0] src1;
        logic [VID_W-1:0] src2;
        logic [VID_W-1:0] dst;
    } cmd_t;

    // Vector storage; contents deliberately survive reset.
    fixed_point_t mem [NUM_VECTORS][D];

    cmd_t             fifo [CMD_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    cmd_t             head;

    state_t           state;
    logic [VID_W-1:0] act_src1;
    logic [VID_W-1:0] act_src2;
    logic [VID_W-1:0] act_dst;
    logic             host_access;
    logic             last_write;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = fifo[rd_ptr[PTR_W-1:0]];

    assign cmd_ready_o  = !full;
    assign push         = cmd_valid_i && !full;
    assign host_ready_o = (state == IDLE) && empty;
    assign host_access  = host_en_i && host_ready_o;
    assign pop          = (state == IDLE) && !empty && !host_access;
    assign busy_o       = !empty || (state != IDLE);
    assign last_write   = (state == BUSY) && fu_w_en_i && (fu_addr_i == DI_t'(D - 1));

    // Reads are combinational so in-place (src == dst) operations see the old
    // element value in the same cycle the FU writes the new one.
    assign fu_vector1_r_data_o = mem[act_src1][fu_addr_i];
    assign fu_vector2_r_data_o = mem[act_src2][fu_addr_i];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo[wr_ptr[PTR_W-1:0]] <= '{op: cmd_op_i, src1: cmd_src1_i,
                                         src2: cmd_src2_i, dst: cmd_dst_i};
        end
    end

    // FU writes only land in BUSY; host writes only when idle with an empty
    // queue, so the two writers never collide.
    always_ff @(posedge clk_i) begin
        if ((state == BUSY) && fu_w_en_i) begin
            mem[act_dst][fu_addr_i] <= fu_w_data_i;
        end else if (host_access && host_we_i) begin
            mem[host_vec_i][host_addr_i] <= host_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            act_src1       <= '0;
            act_src2       <= '0;
            act_dst        <= '0;
            fu_operation_o <= operation_t'('0);
            fu_in_valid_o  <= 1'b0;
            done_o         <= 1'b0;
            done_dst_o     <= '0;
            host_rdata_o   <= '0;
        end else begin
            done_o <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (host_access && !host_we_i) begin
                host_rdata_o <= mem[host_vec_i][host_addr_i];
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        fu_operation_o <= head.op;
                        act_src1       <= head.src1;
                        act_src2       <= head.src2;
                        act_dst        <= head.dst;
                        fu_in_valid_o  <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (fu_in_ready_i) begin
                        fu_in_valid_o <= 1'b0;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    if (last_write) begin
                        done_o         <= 1'b1;
                        done_dst_o     <= act_dst;
                        fu_operation_o <= operation_t'('0);
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ROWWISE_SEQ_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cmds_o        <= '0;
            perf_busy_cycles_o <= '0;
        end else begin
            if (last_write) begin
                perf_cmds_o <= perf_cmds_o + 32'd1;
            end
            if (state != IDLE) begin
                perf_busy_cycles_o <= perf_busy_cycles_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rowwise_sequencer.sv
// Testbench for rowwise_sequencer: directed steps with a behavioural FU model
// and scoreboard queues for done_dst_o and host read data.
module tb_rowwise_sequencer;
    import config_pkg::*;

    localparam int unsigned NV = 8;
    localparam int unsigned VW = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    operation_t       cmd_op;
    logic [VW-1:0]    cmd_src1, cmd_src2, cmd_dst;
    logic             fu_in_ready;
    logic             fu_in_valid;
    operation_t       fu_operation;
    DI_t              fu_addr;
    logic             fu_w_en;
    fixed_point_t     fu_w_data;
    fixed_point_t     fu_v1, fu_v2;
    logic             done;
    logic [VW-1:0]    done_dst;
    logic             busy;
    logic             host_en, host_we;
    logic [VW-1:0]    host_vec;
    DI_t              host_addr;
    fixed_point_t     host_wdata;
    logic             host_ready;
    fixed_point_t     host_rdata;
`ifdef ROWWISE_SEQ_PERF_EN
    logic [31:0]      perf_cmds, perf_busy_cycles;
`endif

    rowwise_sequencer #(.NUM_VECTORS(NV), .CMD_DEPTH(4)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .cmd_valid_i         (cmd_valid),
        .cmd_ready_o         (cmd_ready),
        .cmd_op_i            (cmd_op),
        .cmd_src1_i          (cmd_src1),
        .cmd_src2_i          (cmd_src2),
        .cmd_dst_i           (cmd_dst),
        .fu_in_ready_i       (fu_in_ready),
        .fu_in_valid_o       (fu_in_valid),
        .fu_operation_o      (fu_operation),
        .fu_addr_i           (fu_addr),
        .fu_w_en_i           (fu_w_en),
        .fu_w_data_i         (fu_w_data),
        .fu_vector1_r_data_o (fu_v1),
        .fu_vector2_r_data_o (fu_v2),
        .done_o              (done),
        .done_dst_o          (done_dst),
        .busy_o              (busy),
        .host_en_i           (host_en),
        .host_we_i           (host_we),
        .host_vec_i          (host_vec),
        .host_addr_i         (host_addr),
        .host_wdata_i        (host_wdata),
        .host_ready_o        (host_ready),
        .host_rdata_o        (host_rdata)
`ifdef ROWWISE_SEQ_PERF_EN
        ,
        .perf_cmds_o         (perf_cmds),
        .perf_busy_cycles_o  (perf_busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [VW-1:0] exp_dst_q [$];
    fixed_point_t  exp_rd_q  [$];
    int            done_seen = 0;
    int            issue_cnt = 0;
    int unsigned   issue_cyc = 0;
    int unsigned   done_cyc  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the next queued destination.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_dst_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
            else                       check("done_dst", 32'(done_dst), 32'(exp_dst_q.pop_front()));
            done_seen++;
            done_cyc = cyc;
        end
        if (rst_n && fu_in_valid && fu_in_ready) begin
            issue_cnt++;
            issue_cyc = cyc;
        end
    end

    // Behavioural FU: one idle cycle after the handshake, then one element
    // write per cycle for addresses 0..D-1.
    logic       fu_idle;
    logic       fu_hold;
    operation_t fu_op;
    assign fu_in_ready = fu_idle && !fu_hold;

    function automatic fixed_point_t alu(input operation_t op, input fixed_point_t a, input fixed_point_t b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return fixed_point_t'(a * b);
            default: return (a > b) ? a : b;
        endcase
    endfunction

    initial begin : fu_model
        fu_idle = 1'b1; fu_hold = 1'b0; fu_w_en = 1'b0; fu_addr = '0; fu_w_data = '0;
        fu_op = OP_ADD;
        forever begin
            @(negedge clk);
            if (rst_n && fu_in_valid && fu_in_ready) begin
                fu_op = fu_operation;
                @(posedge clk); #1;
                fu_idle = 1'b0;
                @(posedge clk); #1;
                for (int i = 0; i < int'(D); i++) begin
                    if (!rst_n) break;
                    fu_addr = DI_t'(i);
                    #1;
                    fu_w_data = alu(fu_op, fu_v1, fu_v2);
                    fu_w_en   = 1'b1;
                    @(posedge clk); #1;
                end
                fu_w_en = 1'b0;
                fu_idle = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic host_write(input int vec, input int addr, input int data);
        host_en = 1'b1; host_we = 1'b1;
        host_vec = VW'(vec); host_addr = DI_t'(addr); host_wdata = fixed_point_t'(data);
        step();
        host_en = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_read(input int vec, input int addr, input int exp, input string tag);
        host_en = 1'b1; host_we = 1'b0;
        host_vec = VW'(vec); host_addr = DI_t'(addr);
        exp_rd_q.push_back(fixed_point_t'(exp));
        step();
        host_en = 1'b0;
        @(negedge clk);
        check(tag, 32'(host_rdata), 32'(exp_rd_q.pop_front()));
        step();
    endtask

    task automatic send_cmd(input operation_t op, input int s1, input int s2, input int d);
        cmd_valid = 1'b1; cmd_op = op;
        cmd_src1 = VW'(s1); cmd_src2 = VW'(s2); cmd_dst = VW'(d);
        @(negedge clk);
        if (cmd_ready) exp_dst_q.push_back(VW'(d));
        else           check("cmd_accept", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int k = 0;
        while (done_seen < n && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(done_seen), 32'(n));
    endtask

    int          accepted;
    int          done_base;
    int unsigned c0;

    initial begin : stimulus
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_ADD;
        cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0;
        host_en = 1'b0; host_we = 1'b0; host_vec = '0; host_addr = '0; host_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_valid", 32'(fu_in_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_dst", 32'(done_dst), 32'd0);
        check("rst_rdata", 32'(host_rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_host_ready", 32'(host_ready), 32'd1);
        check("rst_op", 32'(fu_operation), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Test 1: load v0[i]=i, v1[i]=2; ADD 0,1 -> 2
        for (int i = 0; i < int'(D); i++) begin
            host_write(0, i, i);
            host_write(1, i, 2);
        end
        c0 = cyc;
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_src1 = 3'd0; cmd_src2 = 3'd1; cmd_dst = 3'd2;
        @(negedge clk);
        if (cmd_ready) exp_dst_q.push_back(3'd2);
        check("t1_valid_c0", 32'(fu_in_valid), 32'd0);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t1_valid_c1", 32'(fu_in_valid), 32'd0);
        check("t1_host_ready_queued", 32'(host_ready), 32'd0);
        step();
        @(negedge clk);
        check("t1_valid_c2", 32'(fu_in_valid), 32'd1);
        check("t1_valid_cycle", cyc - c0, 32'd2);
        step();
        wait_done(1, 40, "t1_done_count");
        step();
        check("t1_issue_pulses", 32'(issue_cnt), 32'd1);
        for (int i = 0; i < int'(D); i++) host_read(2, i, i + 2, "t1_v2");

        // Test 2: in-place SUB 2,1 -> 2
        send_cmd(OP_SUB, 2, 1, 2);
        wait_done(2, 40, "t2_done_count");
        check("t2_issue_to_done", done_cyc - issue_cyc, 32'(D + 2));
        step();
        for (int i = 0; i < int'(D); i++) host_read(2, i, i, "t2_v2");
`ifdef ROWWISE_SEQ_PERF_EN
        check("perf_cmds", perf_cmds, 32'd2);
`endif

        // Test 3: FU stalled, offer 6 commands; one goes active, four fill the FIFO
        fu_hold = 1'b1;
        done_base = done_seen;
        accepted = 0;
        for (int k = 0; k < 6; k++) begin
            cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_src1 = 3'd0; cmd_src2 = 3'd1;
            cmd_dst = VW'(3 + (k % 5));
            @(negedge clk);
            if (cmd_ready) begin
                exp_dst_q.push_back(VW'(3 + (k % 5)));
                accepted++;
            end
            step();
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t3_accepted", 32'(accepted), 32'd5);
        check("t3_cmd_ready_full", 32'(cmd_ready), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_valid_held", 32'(fu_in_valid), 32'd1);
        step();
        fu_hold = 1'b0;
        wait_done(done_base + 5, 200, "t3_done_count");
        step();
        check("t3_queue_drained", 32'(exp_dst_q.size()), 32'd0);
        for (int i = 0; i < int'(D); i++) host_read(7, i, i + 2, "t3_v7");

        // Test 4: FU not ready for 10 cycles in ISSUE
        fu_hold = 1'b1;
        done_base = done_seen;
        send_cmd(OP_SUB, 0, 1, 3);
        step();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t4_valid_hold", 32'(fu_in_valid), 32'd1);
            check("t4_op_stable", 32'(fu_operation), 32'(OP_SUB));
            step();
        end
        fu_hold = 1'b0;
        @(negedge clk);
        check("t4_handshake_valid", 32'(fu_in_valid), 32'd1);
        step();
        @(negedge clk);
        check("t4_busy_entered", 32'(fu_in_valid), 32'd0);
        check("t4_op_in_busy", 32'(fu_operation), 32'(OP_SUB));
        step();
        wait_done(done_base + 1, 40, "t4_done_count");
        step();
        for (int i = 0; i < int'(D); i++) host_read(3, i, i - 2, "t4_v3");

        // Test 5: reset at element D/2 of a MUL with a second command queued
        done_base = done_seen;
        send_cmd(OP_MUL, 0, 1, 6);
        send_cmd(OP_ADD, 0, 1, 5);
        begin
            int k = 0;
            @(negedge clk);
            while (!(fu_w_en && fu_addr == DI_t'(D / 2)) && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("t5_reached_mid", 32'(fu_addr), 32'(D / 2));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_valid", 32'(fu_in_valid), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_done_dst", 32'(done_dst), 32'd0);
        check("t5_rdata", 32'(host_rdata), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t5_op", 32'(fu_operation), 32'd0);
        exp_dst_q.delete();
        step();
        step();
        rst_n = 1'b1;
        repeat (30) step();
        @(negedge clk);
        check("t5_no_done", 32'(done_seen), 32'(done_base));
        check("t5_host_ready", 32'(host_ready), 32'd1);
        check("t5_busy_after", 32'(busy), 32'd0);
        step();

        // Test 6: host write while BUSY is dropped
        done_base = done_seen;
        send_cmd(OP_ADD, 0, 1, 4);
        repeat (3) step();
        host_en = 1'b1; host_we = 1'b1; host_vec = 3'd0; host_addr = '0; host_wdata = 16'h7777;
        @(negedge clk);
        check("t6_host_ready", 32'(host_ready), 32'd0);
        step();
        host_en = 1'b0; host_we = 1'b0;
        wait_done(done_base + 1, 40, "t6_done_count");
        step();
        host_read(0, 0, 0, "t6_v0_unchanged");
        host_read(4, 5, 7, "t6_v4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
